pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM pipeline buffers. The EX/MEM buffer is never frozen except on a memory hold.
- Keeps an internal destination-register scoreboard that mirrors the EX, MEM and WB stages. It stalls decode on read-after-write (RAW) hazards; the pipeline has no forwarding.
- Flushes younger instructions when a branch or jump resolves taken in MEM, and counts stall, flush and hold cycles for performance debug.

Parameters:
REG_AW, 6, register-address width (64 registers, no hardwired zero)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register 1
id_rs_used  in  1  instruction reads id_rs
id_rt  in  REG_AW  ID source register 2
id_rt_used  in  1  instruction reads id_rt
id_rd  in  REG_AW  ID destination register
id_regwrite  in  1  ID instruction writes id_rd (RegWrite or PCtoReg)
mem_take_branch  in  1  MEM-stage redirect: (BrZ&Z)|(BrN&N)|jump|jump_mem
mem_busy  in  1  data memory not ready; freeze the whole pipeline
pc_we  out  1  PC register update enable
ifid_we  out  1  IF/ID buffer load enable
ifid_flush  out  1  load bubble into IF/ID
idex_flush  out  1  load bubble (ctrl=0) into ID/EX
exmem_flush  out  1  load bubble (ctrl=0) into EX/MEM
pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB buffers
pc_redirect  out  1  select the MEM-stage pc_plus_imm / jump target as next PC
ctrl_state  out  1  0=RUN, 1=HOLD
stall_cnt  out  CNT_W  RAW stall cycles, saturating
flush_cnt  out  CNT_W  redirect events, saturating
hold_cnt  out  CNT_W  mem_busy cycles, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - Scoreboard entries invalid, all counters 0, ctrl_state=RUN.
  - While rst_n is low, outputs are forced to: pc_we=0, ifid_we=0, ifid_flush=idex_flush=exmem_flush=1, pipe_hold=0, pc_redirect=0.
  - First normal-control cycle is the first rising edge after rst_n deasserts.
- Scoreboard: three entries {v, rd} named SB_EX, SB_MEM, SB_WB.
- Hazard term:
  - raw = id_valid & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt))).
  - match(r) is true if any valid entry's rd equals r.
  - SB_WB is included because the register file writes on the same edge that ID reads would be captured.
- Control outputs are combinational from inputs and state, with priority per cycle:
  1. mem_busy=1:
     - pipe_hold=1, pc_we=0, ifid_we=0, all flushes 0, pc_redirect=0.
     - Scoreboard unchanged; hold_cnt increments.
     - A pending mem_take_branch is not acted on; it stays asserted because EX/MEM is frozen.
  2. mem_take_branch=1:
     - pc_redirect=1, pc_we=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
     - Any RAW condition is ignored; flush_cnt increments.
  3. raw=1:
     - pc_we=0, ifid_we=0, idex_flush=1; stall_cnt increments.
  4. Otherwise: pc_we=1, ifid_we=1, everything else 0.
- Scoreboard update at posedge when not held:
  - SB_WB <= SB_MEM.
  - SB_MEM <= exmem_flush ? invalid : SB_EX.
  - SB_EX <= (idex_flush) ? invalid : {id_valid&id_regwrite, id_rd}.
  - The redirecting branch itself advances MEM to WB with its own entry, so PCtoReg writes are tracked.
- FSM ctrl_state:
  - RUN -> HOLD on a posedge with mem_busy=1.
  - HOLD -> RUN on a posedge with mem_busy=0.
  - ctrl_state is a registered copy of mem_busy, used for debug and for the hold counter.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones without wrapping.
  - Counters are read-only; only reset clears them.
- Latency:
  - A RAW stall lasts until the producer leaves SB_WB, i.e. at most 3 cycles per producer.
  - A redirect costs 3 bubbles.

Test Plan:
- Reset, then id_valid=1, id_regwrite=1, id_rd=5, with no hazards for 4 cycles -> pc_we=ifid_we=1 every cycle; SB_EX.rd=5 after the first edge; all counters 0.
- Producer rd=7 enters, then the next instruction reads id_rs=7 (id_rs_used=1) -> exactly 3 cycles with pc_we=0 and idex_flush=1; stall_cnt=3; issue on the 4th cycle.
- Producer rd=9; one cycle later mem_take_branch=1 while ID reads r9 -> redirect wins: pc_redirect=1 and all three flushes=1 in that cycle; stall_cnt unchanged; flush_cnt=1; SB_EX and SB_MEM invalid afterwards.
- mem_busy=1 for 5 cycles during a RAW stall -> pipe_hold=1, no flush, scoreboard frozen; hold_cnt=5; ctrl_state=1 from the 2nd cycle; the stall resumes counting afterwards.
- mem_busy and mem_take_branch both asserted for 2 cycles, then mem_busy=0 -> no redirect during the hold; pc_redirect=1 in the first cycle after the hold.
- Preload stall_cnt to near saturation (CNT_W=4 build), then 20 RAW cycles -> stall_cnt stays at 15. Assert rst_n=0 mid-stall -> outputs change immediately with no clock edge, and all counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW interlock from a
// three-entry destination scoreboard, MEM-stage redirect flush, memory hold.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              mem_take_branch,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pipe_hold,
  output logic              pc_redirect,
  output logic              ctrl_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  hold_cnt
);

  // state | meaning
  // RUN   | last edge saw mem_busy=0; pipeline free to advance
  // HOLD  | last edge saw mem_busy=1; pipeline was frozen
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } sb_entry_t;

  state_t    state;
  sb_entry_t sb_ex, sb_mem, sb_wb;
  logic      rs_hit, rt_hit, raw;

  function automatic logic sb_match(input logic [REG_AW-1:0] r,
                                    input sb_entry_t a,
                                    input sb_entry_t b,
                                    input sb_entry_t c);
    return (a.v && a.rd == r) || (b.v && b.rd == r) || (c.v && c.rd == r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // WB is part of the match set: the register file write and the ID read
  // land on the same edge, and there is no forwarding path.
  assign rs_hit = id_rs_used && sb_match(id_rs, sb_ex, sb_mem, sb_wb);
  assign rt_hit = id_rt_used && sb_match(id_rt, sb_ex, sb_mem, sb_wb);
  assign raw    = id_valid && (rs_hit || rt_hit);

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    pc_redirect = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_busy) begin
      pipe_hold = 1'b1;
    end else if (mem_take_branch) begin
      pc_redirect = 1'b1;
      pc_we       = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (raw) begin
      idex_flush = 1'b1;
    end else begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (mem_busy)  state <= HOLD;
        HOLD:    if (!mem_busy) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign ctrl_state = state;

  // The redirecting branch itself moves MEM->WB with its entry intact so a
  // PCtoReg write stays tracked; only the younger EX and ID slots are killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!mem_busy) begin
      sb_wb  <= sb_mem;
      sb_mem <= exmem_flush ? '0 : sb_ex;
      sb_ex  <= idex_flush ? '0 : '{v: id_valid & id_regwrite, rd: id_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      if (mem_busy)
        hold_cnt <= sat_inc(hold_cnt);
      else if (mem_take_branch)
        flush_cnt <= sat_inc(flush_cnt);
      else if (raw)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus
// randomized traffic against an in-flight-instruction model.
module tb_pipe_hazard_ctrl;
  localparam int REG_AW = 6;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  bit clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs_used, id_rt_used, id_regwrite, mem_take_branch, mem_busy;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_redirect, ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, hold_cnt;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .mem_take_branch(mem_take_branch), .mem_busy(mem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pipe_hold(pipe_hold), .pc_redirect(pc_redirect),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  // In-flight instructions younger-first: slot 0 in EX, 1 in MEM, 2 in WB.
  bit m_v[3];
  int m_rd[3];
  int m_stall, m_flush, m_hold;
  bit m_busy_prev;

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_redirect}
  always @(negedge clk) begin
    logic [6:0] act, exp_v;
    logic [3*CNT_W:0] act_c, exp_c;
    bit hazard;
    act = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_redirect};
    act_c = {ctrl_state, stall_cnt, flush_cnt, hold_cnt};
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_rd[i] = 0; end
      m_stall = 0; m_flush = 0; m_hold = 0; m_busy_prev = 0;
      exp_v = 7'b0011100;
    end else begin
      hazard = 0;
      for (int i = 0; i < 3; i++)
        if (m_v[i] && ((id_rs_used && m_rd[i] == int'(id_rs)) ||
                       (id_rt_used && m_rd[i] == int'(id_rt))))
          hazard = id_valid;
      if (mem_busy)             exp_v = 7'b0000010;
      else if (mem_take_branch) exp_v = 7'b1011101;
      else if (hazard)          exp_v = 7'b0001000;
      else                      exp_v = 7'b1100000;
    end
    exp_c = {m_busy_prev, CNT_W'(m_stall), CNT_W'(m_flush), CNT_W'(m_hold)};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL ctrl_outputs t=%0t actual=%b required=%b", $time, act, exp_v);
    end
    checks++;
    if (act_c !== exp_c) begin
      failures++;
      $display("FAIL state_counters t=%0t actual=%h required=%h", $time, act_c, exp_c);
    end
    if (rst_n) begin
      if (mem_busy) begin
        m_hold = sat(m_hold);
      end else begin
        if (mem_take_branch) m_flush = sat(m_flush);
        else if (hazard) m_stall = sat(m_stall);
        m_v[2] = m_v[1]; m_rd[2] = m_rd[1];
        m_v[1] = mem_take_branch ? 1'b0 : m_v[0]; m_rd[1] = m_rd[0];
        m_v[0] = (mem_take_branch || hazard) ? 1'b0 : (id_valid && id_regwrite);
        m_rd[0] = int'(id_rd);
      end
      m_busy_prev = mem_busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit rw, input bit br, input bit busy);
    id_valid = v; id_rs = REG_AW'(rs); id_rs_used = rsu; id_rt = REG_AW'(rt);
    id_rt_used = rtu; id_rd = REG_AW'(rd); id_regwrite = rw;
    mem_take_branch = br; mem_busy = busy;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // Hold the current ID inputs until the instruction issues; returns stall cycles.
  task automatic wait_issue(output int stalls);
    bit issued;
    stalls = 0;
    issued = 0;
    for (int k = 0; k < 10 && !issued; k++) begin
      #2;
      if (pc_we) issued = 1;
      else stalls++;
      tick();
    end
    if (!issued) chk("issue_timeout", 32'(stalls), 32'd3);
  endtask

  initial begin
    int st;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_ctrl_state", 32'(ctrl_state), 0);

    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0);
      #2 chk("no_hazard_issue", {30'd0, pc_we, ifid_we}, 32'd3);
      tick();
    end
    idle(3);
    chk("no_hazard_counts", {stall_cnt, flush_cnt, hold_cnt}, 0);

    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    set_in(1, 7, 1, 0, 0, 3, 0, 0, 0);
    wait_issue(st);
    chk("raw_stall_cycles", 32'(st), 32'd3);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);
    idle(3);

    set_in(1, 0, 0, 0, 0, 9, 1, 0, 0); tick();
    set_in(1, 9, 1, 0, 0, 0, 0, 1, 0);
    #2 chk("redirect_outputs", {pc_we, ifid_flush, idex_flush, exmem_flush, pc_redirect}, 32'h1f);
    tick();
    set_in(1, 9, 1, 0, 0, 0, 0, 0, 0);
    #2 chk("producer_squashed", 32'(pc_we), 32'd1);
    tick();
    chk("redirect_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("redirect_stall_cnt", 32'(stall_cnt), 32'd3);
    idle(3);

    set_in(1, 0, 0, 0, 0, 12, 1, 0, 0); tick();
    set_in(1, 0, 0, 12, 1, 0, 0, 0, 0);
    #2 chk("hold_pre_stall", 32'(pc_we), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 12, 1, 0, 0, 0, 1);
      #2 chk("hold_outputs", {29'd0, pipe_hold, idex_flush, ctrl_state}, {31'd2, 1'(i > 0)});
      tick();
    end
    chk("hold_cnt_5", 32'(hold_cnt), 32'd5);
    set_in(1, 0, 0, 12, 1, 0, 0, 0, 0);
    wait_issue(st);
    chk("stall_after_hold", 32'(st), 32'd2);
    chk("stall_cnt_after_hold", 32'(stall_cnt), 32'd6);
    idle(3);

    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #2 chk("branch_during_hold", 32'(pc_redirect), 32'd0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("branch_after_hold", 32'(pc_redirect), 32'd1);
    tick();
    idle(3);
    chk("flush_hold_cnts", {flush_cnt, hold_cnt}, {CNT_W'(2), CNT_W'(7)});

    set_in(1, 20, 1, 0, 0, 20, 1, 0, 0);
    repeat (29) tick();
    chk("stall_saturated", 32'(stall_cnt), CMAX);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_redirect}, 32'h1c);
    chk("async_reset_counts", {ctrl_state, stall_cnt, flush_cnt, hold_cnt}, 0);
    tick();
    idle(2);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(99) < 85, $urandom_range(7), $urandom_range(99) < 70,
             $urandom_range(7), $urandom_range(99) < 70, $urandom_range(7),
             $urandom_range(99) < 60, $urandom_range(99) < 10, $urandom_range(99) < 15);
      tick();
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
